// File: rtl/tail_light_monitor.sv
// Observer for the 6-lamp tail-light bus {LC,LB,LA,RA,RB,RC}: decodes mode/step,
// pulses done on completed sequences and latches the first pattern/transition error.
module tail_light_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       y,
    input  logic             err_clr,
    output logic [1:0]       mode,
    output logic [1:0]       step,
    output logic             done,
    output logic [CNT_W-1:0] seq_count,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ
    } state_t;

    localparam logic [1:0] ERR_PAT = 2'b01;
    localparam logic [1:0] ERR_TR  = 2'b10;

    state_t           r_state;
    logic [1:0]       r_off;
    logic [1:0]       r_mode;
    logic [1:0]       r_step;
    logic             r_done;
    logic [CNT_W-1:0] r_seq_count;
    logic             r_err;
    logic [1:0]       r_err_code;

    state_t     w_pat;
    logic       w_legal;
    logic [1:0] w_step;
    logic [1:0] w_mode;
    logic       w_trans_ok;
    logic       w_err_new;
    logic [1:0] w_err_code;
    logic       w_done;

    always_comb begin
        w_pat   = S_IDLE;
        w_legal = 1'b1;
        case (y)
            6'b000000: w_pat = S_IDLE;
            6'b001000: w_pat = S_L1;
            6'b011000: w_pat = S_L2;
            6'b111000: w_pat = S_L3;
            6'b000100: w_pat = S_R1;
            6'b000110: w_pat = S_R2;
            6'b000111: w_pat = S_R3;
            6'b111111: w_pat = S_HZ;
            default:   w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_step = 2'd0;
        w_mode = 2'b00;
        case (w_pat)
            S_L1:    begin w_step = 2'd1; w_mode = 2'b10; end
            S_L2:    begin w_step = 2'd2; w_mode = 2'b10; end
            S_L3:    begin w_step = 2'd3; w_mode = 2'b10; end
            S_R1:    begin w_step = 2'd1; w_mode = 2'b01; end
            S_R2:    begin w_step = 2'd2; w_mode = 2'b01; end
            S_R3:    begin w_step = 2'd3; w_mode = 2'b01; end
            S_HZ:    begin w_step = 2'd1; w_mode = 2'b11; end
            default: begin w_step = 2'd0; w_mode = 2'b00; end
        endcase
    end

    // Every non-idle state may fall back to IDLE; only IDLE may enter a sequence.
    always_comb begin
        w_trans_ok = 1'b0;
        case (r_state)
            S_IDLE:  w_trans_ok = (w_pat == S_IDLE) || (w_pat == S_L1) ||
                                  (w_pat == S_R1)   || (w_pat == S_HZ);
            S_L1:    w_trans_ok = (w_pat == S_L2) || (w_pat == S_IDLE);
            S_L2:    w_trans_ok = (w_pat == S_L3) || (w_pat == S_IDLE);
            S_R1:    w_trans_ok = (w_pat == S_R2) || (w_pat == S_IDLE);
            S_R2:    w_trans_ok = (w_pat == S_R3) || (w_pat == S_IDLE);
            default: w_trans_ok = (w_pat == S_IDLE);
        endcase
    end

    always_comb begin
        w_err_new  = !w_legal || !w_trans_ok;
        w_err_code = w_legal ? ERR_TR : ERR_PAT;
        w_done     = w_legal && w_trans_ok && (w_pat == S_IDLE) &&
                     ((r_state == S_L3) || (r_state == S_R3) || (r_state == S_HZ));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_off       <= 2'd2;
            r_mode      <= 2'b00;
            r_step      <= 2'd0;
            r_done      <= 1'b0;
            r_seq_count <= '0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_done <= w_done;
            if (w_done && (r_seq_count != {CNT_W{1'b1}})) begin
                r_seq_count <= r_seq_count + 1'b1;
            end

            // An illegal pattern drops to IDLE but is not an OFF sample for mode hold.
            if (!w_legal) begin
                r_state <= S_IDLE;
                r_step  <= 2'd0;
            end else begin
                r_state <= w_pat;
                r_step  <= w_step;
                if (w_pat == S_IDLE) begin
                    if (r_off != 2'd2) begin
                        r_off <= r_off + 2'd1;
                    end
                    if (r_off != 2'd0) begin
                        r_mode <= 2'b00;
                    end
                end else begin
                    r_off  <= 2'd0;
                    r_mode <= w_mode;
                end
            end

            if (w_err_new) begin
                r_err <= 1'b1;
                if (!r_err || err_clr) begin
                    r_err_code <= w_err_code;
                end
            end else if (err_clr) begin
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
            end
        end
    end

    assign mode      = r_mode;
    assign step      = r_step;
    assign done      = r_done;
    assign seq_count = r_seq_count;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Bench for tail_light_monitor: directed table, multi-cycle corner sequences and
// randomized traffic against a pattern-level reference model.
module tb_tail_light_monitor;

  localparam int CNT_W = 8;
  localparam int VW = 2 + 2 + 1 + CNT_W + 1 + 2;

  localparam logic [5:0] P_OFF = 6'b000000;
  localparam logic [5:0] P_L1  = 6'b001000;
  localparam logic [5:0] P_L2  = 6'b011000;
  localparam logic [5:0] P_L3  = 6'b111000;
  localparam logic [5:0] P_R1  = 6'b000100;
  localparam logic [5:0] P_R2  = 6'b000110;
  localparam logic [5:0] P_R3  = 6'b000111;
  localparam logic [5:0] P_HZ  = 6'b111111;
  localparam logic [5:0] P_BAD = 6'b101000;

  logic             clk;
  logic             reset;
  logic [5:0]       y;
  logic             err_clr;
  logic [1:0]       mode;
  logic [1:0]       step;
  logic             done;
  logic [CNT_W-1:0] seq_count;
  logic             err;
  logic [1:0]       err_code;

  tail_light_monitor #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .y         (y),
    .err_clr   (err_clr),
    .mode      (mode),
    .step      (step),
    .done      (done),
    .seq_count (seq_count),
    .err       (err),
    .err_code  (err_code)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [VW-1:0] exp_q[$];

  // reference model: tracks the last legal pattern itself, not a state encoding
  logic [5:0]       m_last;
  int               m_off;
  logic [1:0]       m_mode;
  logic [1:0]       m_step;
  logic             m_done;
  logic [CNT_W-1:0] m_cnt;
  logic             m_err;
  logic [1:0]       m_code;

  function automatic bit is_legal(input logic [5:0] p);
    logic [5:0] legal_set[8];
    legal_set = '{P_OFF, P_L1, P_L2, P_L3, P_R1, P_R2, P_R3, P_HZ};
    for (int i = 0; i < 8; i++) if (legal_set[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ones(input logic [5:0] p);
    int c = 0;
    for (int i = 0; i < 6; i++) c += int'(p[i]);
    return c;
  endfunction

  // next lamp to light: left grows outward (upward bits), right grows downward
  function automatic logic [5:0] succ(input logic [5:0] p);
    logic [5:0] n;
    if (p[5:3] != 0 && p[2:0] != 0) return 6'b0;
    if (p[5:3] != 0) n = p | ((p << 1) & 6'b111000);
    else             n = p | ((p >> 1) & 6'b000111);
    return (n == p) ? 6'b0 : n;
  endfunction

  function automatic logic [1:0] step_of(input logic [5:0] p);
    if (p == P_HZ) return 2'd1;
    return 2'(ones(p));
  endfunction

  function automatic logic [1:0] mode_of(input logic [5:0] p);
    return {p[5:3] != 0, p[2:0] != 0};
  endfunction

  task automatic model_update(input logic [5:0] yv, input logic clr, input logic rst);
    bit         e;
    logic [1:0] ec;
    bit         ok;
    if (rst) begin
      m_last = 0; m_off = 2; m_mode = 0; m_step = 0; m_done = 0;
      m_cnt = 0; m_err = 0; m_code = 0;
      return;
    end
    e = 0; ec = 2'b00; m_done = 0;
    if (!is_legal(yv)) begin
      e = 1; ec = 2'b01;
      m_last = 0; m_step = 0;
    end else begin
      if (yv == 0)          ok = 1;
      else if (m_last == 0) ok = (step_of(yv) == 1);
      else                  ok = (yv == succ(m_last));
      m_done = ok && yv == 0 && m_last != 0 && succ(m_last) == 0;
      m_step = step_of(yv);
      if (yv == 0) begin
        if (m_off < 2) m_off++;
        if (m_off == 2) m_mode = 2'b00;
      end else begin
        m_off = 0;
        m_mode = mode_of(yv);
      end
      m_last = yv;
      if (!ok) begin e = 1; ec = 2'b10; end
    end
    if (m_done && m_cnt != {CNT_W{1'b1}}) m_cnt++;
    if (e) begin
      if (!m_err || clr) m_code = ec;
      m_err = 1;
    end else if (clr) begin
      m_err = 0; m_code = 0;
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {mode, step, done, seq_count, err, err_code};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    n_total++;
    if (act !== expv)
      $display("FAIL %s: got mode=%b step=%0d done=%b cnt=%0d err=%b code=%b, want mode=%b step=%0d done=%b cnt=%0d err=%b code=%b",
               name, act[VW-1-:2], act[VW-3-:2], act[VW-5], act[CNT_W+2:3], act[2], act[1:0],
               expv[VW-1-:2], expv[VW-3-:2], expv[VW-5], expv[CNT_W+2:3], expv[2], expv[1:0]);
    else
      n_pass++;
  endtask

  // driver: apply one sample, then score the registered result against the model
  task automatic drive(input logic [5:0] yv, input logic clr, input logic rst);
    y = yv; err_clr = clr; reset = rst;
    @(posedge clk);
    #1;
    model_update(yv, clr, rst);
    exp_q.push_back({m_mode, m_step, m_done, m_cnt, m_err, m_code});
    check("model", dut_vec(), exp_q.pop_front());
  endtask

  typedef struct {
    logic [5:0]       y;
    logic             clr;
    logic [1:0]       mode;
    logic [1:0]       step;
    logic             done;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic [1:0]       code;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] yv, input logic clr, input logic [1:0] md,
                     input logic [1:0] st, input logic dn, input int cnt,
                     input logic er, input logic [1:0] cd);
    vec_t v;
    v.y = yv; v.clr = clr; v.mode = md; v.step = st; v.done = dn;
    v.cnt = CNT_W'(cnt); v.err = er; v.code = cd;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] ry;
    logic [5:0] pats[8];
    pats = '{P_OFF, P_L1, P_L2, P_L3, P_R1, P_R2, P_R3, P_HZ};
    y = 0; err_clr = 0; reset = 1;

    //   y      clr  mode   step dn cnt err code
    add(P_OFF, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    add(P_OFF, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    add(P_OFF, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    add(P_L1,  0, 2'b10, 1, 0, 0, 0, 2'b00);
    add(P_L2,  0, 2'b10, 2, 0, 0, 0, 2'b00);
    add(P_L3,  0, 2'b10, 3, 0, 0, 0, 2'b00);
    add(P_OFF, 0, 2'b10, 0, 1, 1, 0, 2'b00);
    add(P_OFF, 0, 2'b00, 0, 0, 1, 0, 2'b00);
    add(P_HZ,  0, 2'b11, 1, 0, 1, 0, 2'b00);
    add(P_OFF, 0, 2'b11, 0, 1, 2, 0, 2'b00);
    add(P_HZ,  0, 2'b11, 1, 0, 2, 0, 2'b00);
    add(P_OFF, 0, 2'b11, 0, 1, 3, 0, 2'b00);
    add(P_HZ,  0, 2'b11, 1, 0, 3, 0, 2'b00);
    add(P_OFF, 0, 2'b11, 0, 1, 4, 0, 2'b00);
    add(P_OFF, 0, 2'b00, 0, 0, 4, 0, 2'b00);
    add(P_BAD, 0, 2'b00, 0, 0, 4, 1, 2'b01);
    add(P_L2,  0, 2'b10, 2, 0, 4, 1, 2'b01);
    add(P_OFF, 0, 2'b10, 0, 0, 4, 1, 2'b01);
    add(P_OFF, 1, 2'b00, 0, 0, 4, 0, 2'b00);
    add(P_L1,  0, 2'b10, 1, 0, 4, 0, 2'b00);
    add(P_R2,  0, 2'b01, 2, 0, 4, 1, 2'b10);
    add(P_OFF, 1, 2'b01, 0, 0, 4, 0, 2'b00);
    add(P_L1,  0, 2'b10, 1, 0, 4, 0, 2'b00);
    add(P_L2,  0, 2'b10, 2, 0, 4, 0, 2'b00);
    add(P_OFF, 0, 2'b10, 0, 0, 4, 0, 2'b00);
    add(P_OFF, 0, 2'b00, 0, 0, 4, 0, 2'b00);
    add(P_BAD, 1, 2'b00, 0, 0, 4, 1, 2'b01);
    add(P_OFF, 1, 2'b00, 0, 0, 4, 0, 2'b00);

    // reset held 4 cycles
    for (int i = 0; i < 4; i++) begin
      drive(P_OFF, 0, 1);
      check("reset", dut_vec(), '0);
    end

    foreach (tbl[i]) begin
      drive(tbl[i].y, tbl[i].clr, 0);
      check($sformatf("tbl%0d", i), dut_vec(),
            {tbl[i].mode, tbl[i].step, tbl[i].done, tbl[i].cnt, tbl[i].err, tbl[i].code});
    end

    // counter saturation over 260 right sequences
    for (int i = 0; i < 260; i++) begin
      drive(P_R1, 0, 0); drive(P_R2, 0, 0); drive(P_R3, 0, 0); drive(P_OFF, 0, 0);
    end
    n_total++;
    if (seq_count !== 8'd255) $display("FAIL sat: got cnt=%0d want 255", seq_count);
    else n_pass++;

    // reset mid-sequence, light FSM keeps going
    drive(P_L1, 0, 0);
    drive(P_L2, 0, 0);
    drive(P_L3, 1, 1);
    check("midreset", dut_vec(), '0);
    drive(P_L3, 0, 0);
    check("resync", dut_vec(), {2'b10, 2'd3, 1'b0, CNT_W'(0), 1'b1, 2'b10});

    // randomized traffic, mostly well-formed sequences
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       ry = 6'($urandom_range(0, 63));
        1:       ry = pats[$urandom_range(0, 7)];
        2, 3:    ry = P_OFF;
        default: ry = (m_last == 0) ? pats[$urandom_range(0, 2) == 0 ? 7 : ($urandom_range(0, 1) ? 1 : 4)]
                                    : succ(m_last);
      endcase
      drive(ry, $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
